// File: rtl/io_pkg.sv
// Shared types and defaults for the IO bus controller.
package io_pkg;

  localparam int unsigned DefAddrW = 10;
  localparam int unsigned DefDataW = 32;
  localparam int unsigned CntW     = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StDone,
    StTurn
  } bus_state_e;

  typedef enum logic [1:0] {
    IrqIdle,
    IrqPend,
    IrqAck
  } irq_state_e;

endpackage

// File: rtl/io_irq_sync.sv
// Synchronises the asynchronous IO interrupt and relays it to the CPU as a
// 4-phase interrupt / int_ack handshake.
module io_irq_sync
  import io_pkg::*;
(
  input  logic Clk,
  input  logic Rst_,
  input  logic interrupt,
  input  logic cpu_irq_ack,
  output logic cpu_irq,
  output logic int_ack
);

  logic [1:0] sync_q;
  logic       irq_s;
  irq_state_e state_q, state_d;
  logic       cpu_irq_q, cpu_irq_d;
  logic       int_ack_q, int_ack_d;

  assign irq_s = sync_q[1];

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      sync_q    <= 2'b00;
      state_q   <= IrqIdle;
      cpu_irq_q <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], interrupt};
      state_q   <= state_d;
      cpu_irq_q <= cpu_irq_d;
      int_ack_q <= int_ack_d;
    end
  end

  // Leaving IrqAck needs irq_s low, so a held level can never re-trigger.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IrqIdle: if (irq_s)       state_d = IrqPend;
      IrqPend: if (cpu_irq_ack) state_d = IrqAck;
      IrqAck:  if (!irq_s)      state_d = IrqIdle;
      default:                  state_d = IrqIdle;
    endcase
    cpu_irq_d = (state_d == IrqPend);
    int_ack_d = (state_d == IrqAck);
  end

  assign cpu_irq = cpu_irq_q;
  assign int_ack = int_ack_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU-to-IO bus master: single load/store requests become registered active-low
// CS/RD/WR strobe cycles on the shared tristate data bus.
module io_bus_ctrl
  import io_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              Clk,
  input  logic              Rst_,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_irq,
  input  logic              cpu_irq_ack,
  output logic [ADDR_W-1:0] Addr,
  inout  wire  [DATA_W-1:0] Data,
  output logic              IO_CS_,
  output logic              IO_RD_,
  output logic              IO_WR_,
  input  logic              interrupt,
  output logic              int_ack
);

  bus_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              drive_q, drive_d;
  logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic              ack_q, ack_d;

  always_ff @(posedge Clk or negedge Rst_) begin
    if (!Rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drive_q <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      drive_q <= drive_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
    end
  end

  // Every output flop is loaded on the edge that enters the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    drive_d = drive_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          state_d = StSetup;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          drive_d = cpu_we;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cs_d    = 1'b0;
        rd_d    = we_q;
        wr_d    = ~we_q;
        cnt_d   = we_q ? '0 : CntW'(RD_WAIT - 1);
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          drive_d = 1'b0;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = Data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (!we_q && (TURNAROUND > 0)) begin
          state_d = StTurn;
          cnt_d   = CntW'(TURNAROUND - 1);
        end else begin
          state_d = StIdle;
        end
      end
      StTurn: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Data      = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign Addr      = addr_q;
  assign IO_CS_    = cs_q;
  assign IO_RD_    = rd_q;
  assign IO_WR_    = wr_q;
  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;

  io_irq_sync u_irq (
    .Clk         (Clk),
    .Rst_        (Rst_),
    .interrupt   (interrupt),
    .cpu_irq_ack (cpu_irq_ack),
    .cpu_irq     (cpu_irq),
    .int_ack     (int_ack)
  );

endmodule
